// File: rtl/seq_det_pkg.sv
// Shared types for the parametrised serial-pattern detector: FSM state
// encoding and the fill-counter width helper.
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL = 2'b00,
        HUNT = 2'b01,
        HIT  = 2'b10
    } state_e;

    // Bits needed to count 0..len received bits.
    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector with run-time reloadable pattern and a
// valid-strobed input. The match counter exists only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int           LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b0011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             w_valid,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    output logic             out,
    output logic             busy_fill,
    output logic [CNT_W-1:0] match_count
);

    localparam int             FW        = fill_width(LEN);
    localparam logic [FW-1:0]  FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]  FILL_ONE  = FW'(1);
    localparam logic [FW-1:0]  FILL_ZERO = FW'(0);

    state_e          state_q, state_d;
    logic [LEN-1:0]  shreg_q, shreg_d;
    logic [LEN-1:0]  pat_q, pat_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            out_q, busy_q;

    logic [LEN-1:0]  sh_next_s;
    logic [FW-1:0]   fill_next_s;
    logic            accept_s;
    logic            match_s;

    // Candidate window after an accepted bit and the match decision on it.
    always_comb begin
        accept_s    = w_valid & ~pat_load;
        sh_next_s   = {shreg_q[LEN-2:0], w};
        fill_next_s = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_ONE;
        match_s     = accept_s && (fill_next_s == FILL_FULL) && (sh_next_s == pat_q);
    end

    // Next-state logic: pattern reload has priority, then accepted bits.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        if (pat_load) begin
            pat_d   = pat_in;
            shreg_d = {LEN{1'b0}};
            fill_d  = FILL_ZERO;
            state_d = FILL;
        end else if (accept_s) begin
            if (match_s) begin
                state_d = HIT;
                // Without overlap the window restarts from an empty register.
                if (OVERLAP) begin
                    shreg_d = sh_next_s;
                    fill_d  = fill_next_s;
                end else begin
                    shreg_d = {LEN{1'b0}};
                    fill_d  = FILL_ZERO;
                end
            end else begin
                shreg_d = sh_next_s;
                fill_d  = fill_next_s;
                case (state_q)
                    FILL:    state_d = (fill_next_s == FILL_FULL) ? HUNT : FILL;
                    HUNT:    state_d = HUNT;
                    HIT:     state_d = OVERLAP ? HUNT : ((fill_next_s == FILL_FULL) ? HUNT : FILL);
                    default: state_d = FILL;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, window and registered Moore outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            shreg_q <= {LEN{1'b0}};
            pat_q   <= PATTERN;
            fill_q  <= FILL_ZERO;
            out_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            out_q   <= (state_d == HIT);
            busy_q  <= (fill_d != FILL_FULL);
        end
    end

    assign out       = out_q;
    assign busy_fill = busy_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of edges entering or re-entering HIT.
    always_comb begin
        cnt_d = cnt_q;
        if (match_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; not cleared by a pattern reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations (default, no-overlap,
// 2-bit counter) driven in lockstep and checked against a history-based model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       w, w_valid, pat_load;
    logic [3:0] pat_in;

    logic       out0, busy0, out1, busy1, out2, busy2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_detect_param #(.LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .pat_load(pat_load),
        .pat_in(pat_in), .out(out0), .busy_fill(busy0), .match_count(cnt0));
    seq_detect_param #(.LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .pat_load(pat_load),
        .pat_in(pat_in), .out(out1), .busy_fill(busy1), .match_count(cnt1));
    seq_detect_param #(.LEN(4), .PATTERN(4'b0011), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .pat_load(pat_load),
        .pat_in(pat_in), .out(out2), .busy_fill(busy2), .match_count(cnt2));

    int errors = 0;
    int checks = 0;

    // Reference model: full log of accepted bits; each config remembers where
    // its current window started.
    bit         hist[4096];
    int         n;
    int         rs[3];
    logic [3:0] mpat[3];
    bit         mout[3];
    int         mcnt[3];
    bit         ovl[3]    = '{1'b1, 1'b0, 1'b1};
    int         cmax[3]   = '{255, 255, 3};

    typedef struct {
        bit         v;
        bit         l;
        bit         wb;
        logic [3:0] p;
        bit         eo;
        bit         eb;
        int         ec;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ecnt(input int k);
`ifdef SEQ_DET_MATCH_CNT_EN
        return mcnt[k];
`else
        return 0;
`endif
    endfunction

    function automatic int mask_cnt(input int c);
`ifdef SEQ_DET_MATCH_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            rs[k]   = n;
            mpat[k] = 4'b0011;
            mout[k] = 1'b0;
            mcnt[k] = 0;
        end
    endtask

    task automatic model_step(input bit v, input bit l, input bit wb, input logic [3:0] p);
        bit m;
        if (l) begin
            for (int k = 0; k < 3; k++) begin
                mpat[k] = p;
                rs[k]   = n;
                mout[k] = 1'b0;
            end
        end else if (v) begin
            hist[n] = wb;
            n++;
            for (int k = 0; k < 3; k++) begin
                m = (n - rs[k]) >= 4;
                for (int i = 0; i < 4; i++)
                    if (m && hist[n-4+i] != mpat[k][3-i]) m = 1'b0;
                mout[k] = m;
                if (m) begin
                    if (mcnt[k] < cmax[k]) mcnt[k]++;
                    if (!ovl[k]) rs[k] = n;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("out0",  out0,  mout[0]);
        chk("busy0", busy0, (n - rs[0]) < 4);
        chk("cnt0",  cnt0,  ecnt(0));
        chk("out1",  out1,  mout[1]);
        chk("busy1", busy1, (n - rs[1]) < 4);
        chk("cnt1",  cnt1,  ecnt(1));
        chk("out2",  out2,  mout[2]);
        chk("busy2", busy2, (n - rs[2]) < 4);
        chk("cnt2",  cnt2,  ecnt(2));
    endtask

    // Called at a negedge: drive, let one rising edge pass, compare.
    task automatic apply(input bit v, input bit l, input bit wb, input logic [3:0] p);
        w_valid  = v;
        pat_load = l;
        w        = wb;
        pat_in   = p;
        @(posedge clk);
        model_step(v, l, wb, p);
        @(negedge clk);
        check_model();
    endtask

    task automatic send_bits(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) apply(1'b1, 1'b0, bits[i], 4'b0000);
    endtask

    initial begin
        reset = 1'b0; w = 1'b0; w_valid = 1'b0; pat_load = 1'b0; pat_in = 4'b0000;
        n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out0",  out0,  0);
        chk("rst_busy0", busy0, 1);
        chk("rst_cnt0",  cnt0,  0);
        reset = 1'b1;
        @(negedge clk);

        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b1, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1});
        for (int i = 0; i < 5; i++)
            tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2});

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].l, tbl[i].wb, tbl[i].p);
            chk($sformatf("tbl%0d_out", i),  out0,  tbl[i].eo);
            chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].eb);
            chk($sformatf("tbl%0d_cnt", i),  cnt0,  mask_cnt(tbl[i].ec));
        end

        // Reloaded pattern 0101: overlapping vs restarting windows.
        apply(1'b0, 1'b1, 1'b0, 4'b0101);
        send_bits(4'b0101);
        chk("p5_b4_out1", out1, 1);
        apply(1'b1, 1'b0, 1'b0, 4'b0000);
        chk("p5_b5_busy1", busy1, 1);
        apply(1'b1, 1'b0, 1'b1, 4'b0000);
        chk("p5_b6_out0", out0, 1);
        chk("p5_b6_out1", out1, 0);
        chk("p5_b6_busy1", busy1, 1);
        apply(1'b1, 1'b0, 1'b0, 4'b0000);
        chk("p5_b7_busy1", busy1, 1);
        apply(1'b1, 1'b0, 1'b1, 4'b0000);
        chk("p5_b8_out1", out1, 1);

        // Reset in the middle of a partial pattern.
        apply(1'b1, 1'b0, 1'b0, 4'b0000);
        apply(1'b1, 1'b0, 1'b0, 4'b0000);
        apply(1'b1, 1'b0, 1'b1, 4'b0000);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out0", out0, 0);
        chk("mid_rst_busy1", busy1, 1);
        chk("mid_rst_cnt2", cnt2, 0);
        @(negedge clk);
        reset = 1'b1;
        apply(1'b1, 1'b0, 1'b1, 4'b0000);
        chk("post_rst_out0", out0, 0);
        chk("post_rst_busy0", busy0, 1);
        send_bits(4'b0011);
        chk("post_rst_pat_out0", out0, 1);

        // Five matches since reset: 2-bit counter saturates.
        for (int i = 0; i < 4; i++) send_bits(4'b0011);
        chk("sat_cnt2", cnt2, mask_cnt(3));
        chk("sat_cnt0", cnt0, mask_cnt(5));

        // Randomised traffic, reloads and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_model();
                @(negedge clk);
                reset = 1'b1;
            end
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
